// File: rtl/aes_pkg.sv
// Shared AES constants and types: word/round-key geometry, key-expansion
// FSM states, the Rcon table and the round-count helper.
package aes_pkg;

    localparam int unsigned WORD = 32;
    localparam int unsigned NB   = 4;

    typedef logic [WORD-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DRAIN  = 2'd2
    } state_e;

    // Rcon[1..10] stored at index 0..9; only the top byte of the word is non-zero
    localparam logic [9:0][7:0] RCON = {
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
        8'h10, 8'h08, 8'h04, 8'h02, 8'h01
    };

    // Number of cipher rounds for a key of nk words
    function automatic int unsigned nr(input int unsigned nk);
        return nk + 32'd6;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational.
// Ports: i_byte - input byte; o_byte_c - substituted byte (combinational).
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte_c
);

    // Entry 0 is the leftmost byte of the table
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_byte_c = SBOX[i_byte];

endmodule

// File: rtl/aes_key_expand.sv
// AES key expansion (FIPS-197) producing one round key per NB words.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   key_i/key_valid_i/key_ready_o - cipher key handshake (w[0] in the MS word)
//   rk_o/rk_idx_o/rk_last_o/rk_valid_o/rk_ready_i - round key stream
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int unsigned WORD = 32,
    parameter int unsigned NB   = 4,
    parameter int unsigned NK   = 4,
    parameter int unsigned NR   = NK + 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD*NK-1:0]   key_i,
    input  logic                 key_valid_i,
    output logic                 key_ready_o,
    output logic [WORD*NB-1:0]   rk_o,
    output logic [3:0]           rk_idx_o,
    output logic                 rk_last_o,
    output logic                 rk_valid_o,
    input  logic                 rk_ready_i
);

    localparam int unsigned NWORDS = NB * (NR + 1);
    localparam int unsigned IW     = 6;
    localparam int unsigned KW     = 3;

    if (WORD != 32 || NB != 4) begin : g_bad_geometry
        $error("aes_key_expand: only WORD=32 and NB=4 are supported");
    end
    if (!(NK == 4 || NK == 6 || NK == 8) || NR != nr(NK)) begin : g_bad_key_size
        $error("aes_key_expand: NK must be 4, 6 or 8 and NR must equal NK+6");
    end

    state_e               r_state, w_state_nxt;
    logic [IW-1:0]        r_i;
    logic [KW-1:0]        r_kcnt;       // i mod NK
    logic [3:0]           r_rcon_idx;   // (i/NK)-1 for the next Rcon use
    logic [3:0]           r_round;
    word_t [NK-1:0]       r_win;        // index 0 = w[i-NK], NK-1 = w[i-1]
    word_t [NB-2:0]       r_stage;
    logic [WORD*NB-1:0]   r_rk;
    logic [3:0]           r_rk_idx;
    logic                 r_rk_last;
    logic                 r_rk_valid;
    logic                 r_key_ready;

    logic                 w_key_hs, w_rk_hs, w_nbth, w_gen, w_last_word, w_in_key;
    word_t                w_prev, w_key_word, w_sub_in, w_sub_out, w_new;

    assign w_key_hs    = key_valid_i && r_key_ready;
    assign w_rk_hs     = r_rk_valid && rk_ready_i;
    assign w_nbth      = (r_i[1:0] == 2'(NB - 1));
    // Only the word that completes a round key can stall, on a full unconsumed output
    assign w_gen       = (r_state == EXPAND) && (!w_nbth || !r_rk_valid || rk_ready_i);
    assign w_last_word = (r_i == IW'(NWORDS - 1));
    assign w_in_key    = (r_i < IW'(NK));
    assign w_prev      = r_win[NK-1];
    assign w_sub_in    = (r_kcnt == '0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    // SubWord: one S-box per byte
    for (genvar b = 0; b < 4; b++) begin : g_sub
        aes_sbox u_sbox (
            .i_byte   (w_sub_in[8*b +: 8]),
            .o_byte_c (w_sub_out[8*b +: 8])
        );
    end

    // Next word; while i < NK the window holds the raw key and is read in place
    always_comb begin
        w_key_word = '0;
        for (int j = 0; j < NK; j++) begin
            if (r_kcnt == KW'(j)) w_key_word = r_win[j];
        end
        w_new = r_win[0] ^ w_prev;
        if (w_in_key) begin
            w_new = w_key_word;
        end else if (r_kcnt == '0) begin
            w_new = r_win[0] ^ w_sub_out ^ {RCON[r_rcon_idx], 24'h0};
        end else if (NK == 8 && r_kcnt == KW'(4)) begin
            w_new = r_win[0] ^ w_sub_out;
        end
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_key_hs) w_state_nxt = EXPAND;
            EXPAND:  if (w_gen && w_last_word) w_state_nxt = DRAIN;
            DRAIN:   if (w_rk_hs && r_rk_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Window, counters, staging and output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_ready <= 1'b0;
            r_i         <= '0;
            r_kcnt      <= '0;
            r_rcon_idx  <= '0;
            r_round     <= '0;
            r_win       <= '0;
            r_stage     <= '0;
            r_rk        <= '0;
            r_rk_idx    <= '0;
            r_rk_last   <= 1'b0;
            r_rk_valid  <= 1'b0;
        end else begin
            r_key_ready <= (w_state_nxt == IDLE);
            if (w_key_hs) begin
                for (int j = 0; j < NK; j++) begin
                    r_win[j] <= key_i[WORD*(NK-j)-1 -: WORD];
                end
                r_i        <= '0;
                r_kcnt     <= '0;
                r_rcon_idx <= '0;
                r_round    <= '0;
            end else if (w_gen) begin
                r_i    <= r_i + 1'b1;
                r_kcnt <= (r_kcnt == KW'(NK - 1)) ? '0 : r_kcnt + 1'b1;
                if (!w_in_key) begin
                    r_win <= {w_new, r_win[NK-1:1]};
                    if (r_kcnt == '0) r_rcon_idx <= r_rcon_idx + 1'b1;
                end
                if (!w_nbth) r_stage[r_i[1:0]] <= w_new;
            end

            if (w_gen && w_nbth) begin
                r_rk       <= {r_stage[0], r_stage[1], r_stage[2], w_new};
                r_rk_idx   <= r_round;
                r_rk_last  <= (r_round == 4'(NR));
                r_rk_valid <= 1'b1;
                r_round    <= r_round + 1'b1;
            end else if (w_rk_hs) begin
                r_rk_valid <= 1'b0;
            end
        end
    end

    assign key_ready_o = r_key_ready;
    assign rk_o        = r_rk;
    assign rk_idx_o    = r_rk_idx;
    assign rk_last_o   = r_rk_last;
    assign rk_valid_o  = r_rk_valid;

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: one instance per key size, a GF(2^8)-derived
// reference key schedule, directed FIPS-197 vectors plus random keys and
// random round-key backpressure.
`timescale 1ns/1ps
module tb_aes_key_expand;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    int           sel;
    logic [255:0] key;
    logic         kv, rr;

    logic         kr4, kr6, kr8, l4, l6, l8, v4, v6, v8;
    logic [127:0] rk4, rk6, rk8;
    logic [3:0]   ix4, ix6, ix8;

    aes_key_expand #(.NK(4)) u_dut4 (
        .clk(clk), .rst(rst), .key_i(key[127:0]), .key_valid_i(kv && sel == 4),
        .key_ready_o(kr4), .rk_o(rk4), .rk_idx_o(ix4), .rk_last_o(l4),
        .rk_valid_o(v4), .rk_ready_i(rr && sel == 4));
    aes_key_expand #(.NK(6)) u_dut6 (
        .clk(clk), .rst(rst), .key_i(key[191:0]), .key_valid_i(kv && sel == 6),
        .key_ready_o(kr6), .rk_o(rk6), .rk_idx_o(ix6), .rk_last_o(l6),
        .rk_valid_o(v6), .rk_ready_i(rr && sel == 6));
    aes_key_expand #(.NK(8)) u_dut8 (
        .clk(clk), .rst(rst), .key_i(key[255:0]), .key_valid_i(kv && sel == 8),
        .key_ready_o(kr8), .rk_o(rk8), .rk_idx_o(ix8), .rk_last_o(l8),
        .rk_valid_o(v8), .rk_ready_i(rr && sel == 8));

    logic         cur_kr, cur_l, cur_v;
    logic [127:0] cur_rk;
    logic [3:0]   cur_ix;
    always_comb begin
        case (sel)
            6:       begin cur_kr = kr6; cur_l = l6; cur_v = v6; cur_rk = rk6; cur_ix = ix6; end
            8:       begin cur_kr = kr8; cur_l = l8; cur_v = v8; cur_rk = rk8; cur_ix = ix8; end
            default: begin cur_kr = kr4; cur_l = l4; cur_v = v4; cur_rk = rk4; cur_ix = ix4; end
        endcase
    end

    int           n_vec = 0;
    int           n_err = 0;
    logic [7:0]   sb [256];
    logic [31:0]  wref [60];
    logic [127:0] got [15];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [7:0] r;
        r = (x << n) | (x >> (8 - n));
        return r;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic logic [127:0] exp_rk(input int r);
        return {wref[4*r], wref[4*r+1], wref[4*r+2], wref[4*r+3]};
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input int nk, input logic [255:0] k);
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4 * (nk + 7); i++) begin
            if (i < nk) begin
                wref[i] = k[32*(nk-1-i) +: 32];
            end else begin
                t = wref[i-1];
                if (i % nk == 0) begin
                    rc = 8'h01;
                    for (int j = 1; j < i / nk; j++) rc = gmul(rc, 8'h02);
                    t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                end else if (nk == 8 && i % nk == 4) begin
                    t = subw(t);
                end
                wref[i] = wref[i-nk] ^ t;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for key_ready, then performs the key handshake
    task automatic start_key(input logic [255:0] k, input bit hold, input logic [255:0] k_next,
                             input int max_wait);
        int w;
        w = 0;
        while (!cur_kr && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("key_ready_wait", 128'(w <= max_wait), 128'(1));
        key = k;
        kv  = 1'b1;
        @(posedge clk);
        #1;
        if (hold) key = k_next;
        else      kv  = 1'b0;
    endtask

    // Collects round keys after a handshake; bp = percent of cycles with rk_ready_i low
    task automatic collect(input int nk, input int bp, input int abort_at);
        int           nrr, r, n;
        bit           stall, done;
        logic [127:0] h_rk;
        logic [3:0]   h_ix;
        logic         h_l;
        nrr = nk + 6; r = 0; n = 0; stall = 1'b0; done = 1'b0;
        h_rk = '0; h_ix = '0; h_l = 1'b0;
        while (!done && n < 400) begin
            @(negedge clk);
            if (stall) begin
                chk("stall_valid", 128'(cur_v), 128'(1));
                chk("stall_rk", cur_rk, h_rk);
                chk("stall_idx", 128'(cur_ix), 128'(h_ix));
                chk("stall_last", 128'(cur_l), 128'(h_l));
            end else if (cur_v) begin
                chk($sformatf("nk%0d_rk%0d", nk, r), cur_rk, exp_rk(r));
                chk("rk_idx", 128'(cur_ix), 128'(r));
                chk("rk_last", 128'(cur_l), 128'(r == nrr));
                if (r < 15) got[r] = cur_rk;
                if (bp == 0) chk("rk_latency", 128'(n), 128'(4 * (r + 1)));
                if (abort_at == r) return;
            end
            rr = (bp == 0) ? 1'b1 : ($urandom_range(99) >= 32'(bp));
            if (cur_v && rr) begin
                if (r == nrr) done = 1'b1;
                r++;
                stall = 1'b0;
            end else if (cur_v) begin
                stall = 1'b1;
                h_rk = cur_rk; h_ix = cur_ix; h_l = cur_l;
            end
            n++;
        end
        chk("rounds_delivered", 128'(r), 128'(nrr + 1));
        @(negedge clk);
        rr = 1'b0;
        chk("valid_after_last", 128'(cur_v), 128'(0));
        chk("ready_after_last", 128'(cur_kr), 128'(1));
    endtask

    localparam logic [255:0] K4 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [255:0] K6 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    initial begin
        logic [255:0] ka, kb;
        int           nk_r;
        rst = 1'b1; kv = 1'b0; rr = 1'b0; sel = 4; key = '0;
        build_sbox();

        // Reset values
        #1;
        chk("rst_key_ready", 128'(cur_kr), 128'(0));
        chk("rst_valid", 128'(cur_v), 128'(0));
        chk("rst_rk", cur_rk, 128'(0));
        chk("rst_idx", 128'(cur_ix), 128'(0));
        chk("rst_last", 128'(cur_l), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 128'(cur_kr), 128'(1));

        // FIPS-197 NK=4, no backpressure
        model_expand(4, K4);
        start_key(K4, 1'b0, '0, 50);
        collect(4, 0, -1);
        chk("fips4_rk1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips4_rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Same key with random backpressure
        start_key(K4, 1'b0, '0, 50);
        collect(4, 40, -1);
        chk("fips4_bp_rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // FIPS-197 NK=6 and NK=8
        sel = 6;
        model_expand(6, K6);
        start_key(K6, 1'b0, '0, 50);
        collect(6, 0, -1);
        chk("fips6_rk12", got[12], 128'he98ba06f448c773c8ecc720401002202);
        sel = 8;
        model_expand(8, K8);
        start_key(K8, 1'b0, '0, 50);
        collect(8, 0, -1);
        chk("fips8_rk14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);

        // Random keys, all sizes, with and without backpressure
        for (int t = 0; t < 6; t++) begin
            nk_r = 4 + 2 * (t % 3);
            sel  = nk_r;
            ka = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
            model_expand(nk_r, ka);
            start_key(ka, 1'b0, '0, 50);
            collect(nk_r, (t < 3) ? 0 : 30, -1);
        end

        // Reset while rk3 is presented, then restart
        sel = 4;
        ka = {128'h0, $urandom(), $urandom(), $urandom(), $urandom()};
        model_expand(4, ka);
        start_key(ka, 1'b0, '0, 50);
        collect(4, 0, 3);
        rst = 1'b1;
        #1;
        chk("midrst_valid", 128'(cur_v), 128'(0));
        chk("midrst_rk", cur_rk, 128'(0));
        chk("midrst_idx", 128'(cur_ix), 128'(0));
        chk("midrst_last", 128'(cur_l), 128'(0));
        chk("midrst_key_ready", 128'(cur_kr), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        rr  = 1'b0;
        @(negedge clk);
        chk("midrst_ready_after", 128'(cur_kr), 128'(1));
        chk("midrst_no_partial", 128'(cur_v), 128'(0));
        model_expand(4, K4);
        start_key(K4, 1'b0, '0, 50);
        collect(4, 0, -1);

        // key_valid_i held high with a different key during expansion
        ka = {128'h0, $urandom(), $urandom(), $urandom(), $urandom()};
        kb = {128'h0, $urandom(), $urandom(), $urandom(), $urandom()};
        model_expand(4, ka);
        start_key(ka, 1'b1, kb, 50);
        collect(4, 0, -1);
        model_expand(4, kb);
        start_key(kb, 1'b0, '0, 0);
        collect(4, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
